// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/control slice.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W          = 4;
  localparam int unsigned DRAIN_W        = 2;
  localparam int unsigned HALT_DRAIN_DEF = 3;

  localparam logic [REG_W-1:0] REG_ZERO = 4'h0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

endpackage : pipe_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare between the decode instruction and the load in ID/EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] i_ifid_rs,
  input  logic [REG_W-1:0] i_ifid_rt,
  input  logic             i_ifid_rs_used,
  input  logic             i_ifid_rt_used,
  input  logic             i_idex_mem_read,
  input  logic             i_idex_reg_write,
  input  logic [REG_W-1:0] i_idex_rd,
  output logic             o_load_use
);

  logic w_load_dst;
  logic w_rs_hit;
  logic w_rt_hit;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign w_load_dst = i_idex_mem_read & i_idex_reg_write & (i_idex_rd != REG_ZERO);
  assign w_rs_hit   = i_ifid_rs_used & (i_ifid_rs == i_idex_rd);
  assign w_rt_hit   = i_ifid_rt_used & (i_ifid_rt == i_idex_rd);
  assign o_load_use = w_load_dst & (w_rs_hit | w_rt_hit);

endmodule : hazard_detect

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register enable/flush/bubble control: load-use stall, branch squash,
// halt drain sequencing and saturating stall/flush counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned HALT_DRAIN = HALT_DRAIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       ifid_rs,
  input  logic [3:0]       ifid_rt,
  input  logic             ifid_rs_used,
  input  logic             ifid_rt_used,
  input  logic             id_halt,
  input  logic             idex_mem_read,
  input  logic             idex_reg_write,
  input  logic [3:0]       idex_rd,
  input  logic             ex_branch_taken,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_wen,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [DRAIN_W-1:0] w_drain_nxt;
  logic [CNT_W-1:0]   r_stall_cycles;
  logic [CNT_W-1:0]   r_flush_cycles;
  logic               w_load_use;
  logic               w_stall_inc;
  logic               w_flush_inc;

  hazard_detect u_hazard_detect (
    .i_ifid_rs        (ifid_rs),
    .i_ifid_rt        (ifid_rt),
    .i_ifid_rs_used   (ifid_rs_used),
    .i_ifid_rt_used   (ifid_rt_used),
    .i_idex_mem_read  (idex_mem_read),
    .i_idex_reg_write (idex_reg_write),
    .i_idex_rd        (idex_rd),
    .o_load_use       (w_load_use)
  );

  // State register and drain counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= RUN;
      r_drain_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_nxt;
    end
  end

  // Next-state: a taken branch outranks both the stall and the halt request.
  always_comb begin
    w_state_nxt = r_state;
    w_drain_nxt = r_drain_cnt;
    unique case (r_state)
      RUN: begin
        if (!ex_branch_taken && !w_load_use && id_halt) begin
          w_state_nxt = DRAIN;
          w_drain_nxt = DRAIN_W'(HALT_DRAIN);
        end
      end
      DRAIN: begin
        if (ex_branch_taken) begin
          w_state_nxt = RUN;
          w_drain_nxt = '0;
        end else if (r_drain_cnt <= DRAIN_W'(1)) begin
          w_state_nxt = HALTED;
          w_drain_nxt = '0;
        end else begin
          w_drain_nxt = r_drain_cnt - DRAIN_W'(1);
        end
      end
      HALTED: begin
        w_state_nxt = HALTED;
      end
      default: begin
        w_state_nxt = RUN;
        w_drain_nxt = '0;
      end
    endcase
  end

  // Output decode: enables, squash controls and counter increment strobes.
  always_comb begin
    pc_wen      = 1'b1;
    ifid_wen    = 1'b1;
    ifid_flush  = 1'b0;
    idex_wen    = 1'b1;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    w_stall_inc = 1'b0;
    w_flush_inc = 1'b0;
    unique case (r_state)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          w_flush_inc = 1'b1;
        end else if (w_load_use) begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_bubble = 1'b1;
          w_stall_inc = 1'b1;
        end else if (id_halt) begin
          pc_wen   = 1'b0;
          ifid_wen = 1'b0;
        end
      end
      DRAIN: begin
        if (ex_branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          w_flush_inc = 1'b1;
        end else begin
          pc_wen      = 1'b0;
          ifid_wen    = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      HALTED: begin
        pc_wen   = 1'b0;
        ifid_wen = 1'b0;
        idex_wen = 1'b0;
        halted   = 1'b1;
      end
      default: begin
        pc_wen   = 1'b1;
      end
    endcase
  end

  // Saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_stall_inc && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush_inc && (r_flush_cycles != '1)) begin
        r_flush_cycles <= r_flush_cycles + CNT_W'(1);
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_cycles = r_flush_cycles;

endmodule : pipeline_hazard_ctrl

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Pipeline control block that produces the write-enable, flush and bubble signals consumed by the PC register, the IF/ID register and the decode/execute pipeline register. It detects load-use hazards against the instruction currently held in decode/execute, squashes wrong-path instructions on a taken branch resolved in EX, and sequences the halt drain. It also keeps saturating stall and flush performance counters. It sits beside the decode stage and drives the `enable` and control-zeroing inputs of the pipeline registers.

## Interface
Parameters:
- CNT_W, 16, width of the performance counters
- HALT_DRAIN, 3, cycles from HLT leaving decode until `halted` asserts

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ifid_rs  in  4  source register 1 of the instruction in decode
- ifid_rt  in  4  source register 2 of the instruction in decode
- ifid_rs_used  in  1  decode instruction reads rs
- ifid_rt_used  in  1  decode instruction reads rt
- id_halt  in  1  decode instruction is HLT
- idex_mem_read  in  1  MemRead held in decode/execute register
- idex_reg_write  in  1  RegWrite held in decode/execute register
- idex_rd  in  4  destination register held in decode/execute register
- ex_branch_taken  in  1  branch in EX resolved taken this cycle
- pc_wen  out  1  PC write enable
- ifid_wen  out  1  IF/ID write enable
- ifid_flush  out  1  load NOP into IF/ID at next edge
- idex_wen  out  1  decode/execute register enable
- idex_bubble  out  1  zero all control fields entering decode/execute
- halted  out  1  processor halted
- stall_cycles  out  CNT_W  saturating count of load-use stall cycles
- flush_cycles  out  CNT_W  saturating count of branch flushes

## Operation
- States: RUN, DRAIN, HALTED. Registered state and `drain_cnt` (2 bits); all enable, flush and bubble outputs are combinational from the state and the inputs.
- `load_use` = idex_mem_read & idex_reg_write & (idex_rd != 0) & ((ifid_rs_used & ifid_rs == idex_rd) | (ifid_rt_used & ifid_rt == idex_rd)). Register 0 never hazards.
- RUN, priority order:
  - ex_branch_taken: pc_wen=1, ifid_wen=1, ifid_flush=1, idex_bubble=1. flush_cycles increments. Any load_use or id_halt in the same cycle is ignored, because that decode instruction is on the wrong path.
  - load_use: pc_wen=0, ifid_wen=0, idex_bubble=1, idex_wen=1. stall_cycles increments. id_halt is ignored in the same cycle.
  - id_halt: pc_wen=0, ifid_wen=0, idex_wen=1, idex_bubble=0, so HLT advances into EX. Next state DRAIN with drain_cnt=HALT_DRAIN.
  - otherwise: all enables are 1; flush and bubble are 0.
- DRAIN: pc_wen=0, ifid_wen=0, idex_bubble=1, idex_wen=1. drain_cnt decrements each cycle; when it reaches 1, the next state is HALTED.
  - If ex_branch_taken arrives during DRAIN (an older branch precedes HLT), the halt is cancelled. The block applies the RUN branch response and returns to RUN, and flush_cycles increments.
- HALTED: all enables are 0, flush and bubble are 0, halted=1. Only rst exits this state.
- Both counters saturate at all-ones and never wrap.
- Reset values: state RUN, drain_cnt 0, halted 0, stall_cycles 0, flush_cycles 0. With quiescent inputs this gives pc_wen=ifid_wen=idex_wen=1 and ifid_flush=idex_bubble=0.

## Timing
- Stall and flush outputs respond in the same cycle as their inputs, with no register stage. A load-use stall therefore lasts exactly 1 cycle, because the load leaves decode/execute at the next edge.
- HLT seen in RUN at cycle T: DRAIN during T+1 through T+HALT_DRAIN; halted=1 from T+HALT_DRAIN+1 onward.
- Counters update at the edge that ends the triggering cycle.
- Asserting rst mid-DRAIN or while HALTED returns the block to RUN immediately (asynchronously), with counters cleared.

## Structure
- Package `pipe_ctrl_pkg`: state enum (RUN, DRAIN, HALTED), REG_ZERO=4'h0, default HALT_DRAIN.
- Sub-module `hazard_detect`: the combinational load_use compare, reused later by the forwarding work.
- Counters are inline saturating incrementers.

## Test plan
- Load r3 in decode/execute (idex_mem_read=1, idex_rd=3), decode reads ifid_rt=3 with ifid_rt_used=1 -> pc_wen=0, ifid_wen=0, idex_bubble=1 for one cycle; stall_cycles=1.
- Same as above but idex_rd=0, or ifid_rt_used=0 -> no stall; all enables stay 1.
- ex_branch_taken=1 together with load_use=1 -> ifid_flush=1, idex_bubble=1, pc_wen=1; flush_cycles=1; stall_cycles unchanged.
- id_halt=1 at cycle 10 -> DRAIN during cycles 11-13; halted=1 from cycle 14; all enables 0 from cycle 14 onward.
- id_halt at cycle 10, then ex_branch_taken=1 at cycle 11 -> returns to RUN with flush; halted is never asserted.
- Preload stall_cycles to 16'hFFFF and force one more load-use stall -> stall_cycles holds at 16'hFFFF. Then assert rst mid-DRAIN -> state RUN, all counters 0.
